// File: rtl/inv_cipher_ctrl.sv
// Inverse-cipher sequencing controller: whitens the key, drives the inverse
// round stage for NUM_ROUNDS cycles and hands the plaintext downstream.
module inv_cipher_ctrl #(
    parameter int unsigned NUM_ROUNDS  = 2,
    parameter logic [3:0]  COUNT_START = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_code,
    input  logic [15:0] in_key,
    output logic [15:0] rd_code,
    output logic [3:0]  rd_count,
    output logic [15:0] rd_keyin,
    input  logic [15:0] rd_altered,
    input  logic [15:0] rd_keyout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    state_e      fsm_q, fsm_d;
    logic [15:0] state_q, state_d;
    logic [15:0] key_q, key_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rnd_q, rnd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_code ^ in_key;
                    key_d   = in_key;
                    cnt_d   = COUNT_START;
                    rnd_d   = '0;
                    fsm_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                fsm_d = S_ROUND;
            end
            S_ROUND: begin
                state_d = rd_altered;
                key_d   = rd_keyout;
                cnt_d   = cnt_q + 4'd1;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
        endcase
    end

    // Handshake outputs are masked while rst is high so an abort never
    // shows a stray ready or valid in the reset cycle itself.
    assign in_ready  = (fsm_q == S_IDLE) && !rst;
    assign out_valid = (fsm_q == S_DONE) && !rst;
    assign busy      = (fsm_q != S_IDLE) && !rst;
    assign out_data  = out_valid ? state_q : 16'h0000;

    assign rd_code  = state_q;
    assign rd_keyin = key_q;
    assign rd_count = cnt_q;

endmodule
